calc_alu_sequencer: RTL
=======================

# calc_alu_sequencer

Multi-cycle arithmetic sequencer for the 4-digit calculator datapath. Sits between the calculator control FSM and the operand/result registers: on a start pulse (the FSM's ALU-enable) it latches two operands and an operation code, runs add/subtract in one cycle and multiply/divide iteratively, range-checks the result and returns it with a one-cycle done pulse and error code. The display and result-save logic consume its outputs.

## Interface
- W, 14: operand/result width in bits (holds 0..9999).
- MAXVAL, 9999: largest legal operand/result.
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed.
- start  in  1  one-cycle request pulse; accepted only in IDLE.
- clr  in  1  abort (Clear key); wins over start.
- op  in  2  00 add, 01 sub, 10 mul, 11 div; sampled with start.
- a  in  W  first operand; sampled with start.
- b  in  W  second operand; sampled with start.
- busy  out  1  high from the cycle after accept until done cycle inclusive.
- done  out  1  one-cycle pulse; result/rem/neg/err valid from this cycle.
- result  out  W  result; 0 on any error.
- rem  out  W  division remainder; 0 for other ops and on error.
- neg  out  1  sub only: a<b, result = b-a.
- err  out  2  00 ok, 01 range (operand or result > MAXVAL), 10 divide by zero.

## Operation
- States: IDLE, ADDSUB, MUL, DIV, CHECK, DONE.
- IDLE: start=1 and clr=0 latches a, b, op; next state by op: 00/01→ADDSUB, 10→MUL, 11→DIV. start outside IDLE ignored (no queueing).
- Operand check at accept: a>MAXVAL or b>MAXVAL → skip to CHECK with err=01.
- DIV with b==0 at accept → skip to CHECK with err=10 (range check takes priority if both apply).
- ADDSUB (1 cycle): add: a+b in W+1 bits; sub: |a-b|, neg=(a<b).
- MUL (W cycles): shift-add, LSB-first over b; 2W-bit accumulator.
- DIV (W cycles): restoring division, MSB-first; quotient→result, remainder→rem.
- CHECK (1 cycle): result > MAXVAL (any bit above W-1 set counts) → err=01; on any error result=rem=neg=0.
- DONE (1 cycle): done=1, busy=1; then IDLE.
- result/rem/neg/err hold their values until the next DONE; they change only at DONE entry.
- clr in any state: next state IDLE, busy=0, no done pulse, outputs keep previous values. clr in IDLE with start: start ignored.
- reset: state IDLE; busy, done, result, rem, neg, err all 0; internal registers cleared.

## Timing
- Start accepted at edge k (start high in cycle k): busy=1 from cycle k+1.
- add/sub: done in cycle k+3.
- mul/div: done in cycle k+W+2 (k+16 at W=14).
- Operand range error or divide by zero: done in cycle k+2.
- busy falls in cycle after done; earliest next accept is that cycle (start high in cycle done+1).
- Back-to-back start while busy: dropped, no effect on the running operation.
- clr and reset take effect at the next edge; reset overrides clr.

## Structure
- Shared package calc_pkg: op codes (OP_ADD, OP_SUB, OP_MUL, OP_DIV), err codes (ERR_NONE, ERR_RANGE, ERR_DIV0), state encoding, MAXVAL default.
- One sub-module, calc_iter_core: W-step shift-add multiplier / restoring divider with load, step and mode inputs, exposing accumulator, quotient and remainder; the sequencer owns the step counter and FSM.

## Test plan
- add: a=1234, b=4321, start at k → done at k+3, result=5555, err=00, neg=0; add 9000+1000 → result=0, err=01.
- sub: a=25, b=100 → result=75, neg=1, err=00; a=100, b=25 → result=75, neg=0.
- mul: a=99, b=101 → done at k+16, result=9999; a=100, b=100 → result=0, err=01.
- div: a=9999, b=7 → done at k+16, result=1428, rem=3; a=5, b=0 → done at k+2, err=10, result=0.
- abort/ignore: start mul, clr at k+5 → busy=0 at k+6, no done, previous result held; second start at k+3 during a run → ignored, single done.
- reset mid-divide at k+8 → all outputs 0 at next edge; start one cycle after reset release accepted normally; a=10000 at start → done at k+2, err=01.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: op/err codes, sequencer
// state encoding and default operand width / limit.
package calc_pkg;

  localparam int W_DEF      = 14;
  localparam int MAXVAL_DEF = 9999;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_DIV0  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDSUB,
    ST_MUL,
    ST_DIV,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/calc_iter_core.sv
// Iterative W-step engine: LSB-first shift-add multiplier and MSB-first
// restoring divider sharing one load/step interface.
module calc_iter_core #(
  parameter int W = 14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder
);

  logic [W-1:0] multiplicand;
  logic [W-1:0] divisor;
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W:0]   div_trial;

  // The low half of acc holds the not-yet-consumed multiplier bits; the
  // trial subtraction's top bit is the borrow that decides the quotient bit.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, multiplicand} : '0);
    div_shift = {remainder, quotient[W-1]};
    div_trial = div_shift - {1'b0, divisor};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      quotient     <= '0;
      remainder    <= '0;
      multiplicand <= '0;
      divisor      <= '0;
    end else if (load) begin
      acc          <= {{W{1'b0}}, b};
      quotient     <= a;
      remainder    <= '0;
      multiplicand <= a;
      divisor      <= b;
    end else if (step) begin
      if (!mode) begin
        acc <= {mul_sum, acc[W-1:1]};
      end else if (!div_trial[W]) begin
        remainder <= div_trial[W-1:0];
        quotient  <= {quotient[W-2:0], 1'b1};
      end else begin
        remainder <= div_shift[W-1:0];
        quotient  <= {quotient[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Calculator ALU sequencer: accepts an operation, runs it (1 cycle add/sub,
// W cycles mul/div), range-checks and reports result with a done pulse.
module calc_alu_sequencer
  import calc_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int MAXVAL = MAXVAL_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         clr,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] rem,
  output logic         neg,
  output logic [1:0]   err
);

  localparam int WIDE = 2 * W;
  localparam int CW   = $clog2(W);

  state_t          state;
  logic [1:0]      op_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [1:0]      err_pend;
  logic [WIDE-1:0] res_wide;
  logic            neg_r;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            range_bad;
  logic            core_step;
  logic            core_mode;
  logic [WIDE-1:0] core_acc;
  logic [W-1:0]    core_quo;
  logic [W-1:0]    core_rem;
  logic [W:0]      add_sum;
  logic [W-1:0]    sub_diff;
  logic [WIDE-1:0] check_val;
  logic [1:0]      check_err;

  assign accept    = (state == ST_IDLE) && start && !clr;
  assign range_bad = (a > W'(MAXVAL)) || (b > W'(MAXVAL));
  assign core_step = (state == ST_MUL) || (state == ST_DIV);
  assign core_mode = (op_r == OP_DIV);

  calc_iter_core #(.W(W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (core_step),
    .mode      (core_mode),
    .a         (a),
    .b         (b),
    .acc       (core_acc),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // Any set bit above the result width counts as out of range, so the
  // comparison is done on the full-width value.
  always_comb begin
    add_sum   = {1'b0, a_r} + {1'b0, b_r};
    sub_diff  = (a_r < b_r) ? (b_r - a_r) : (a_r - b_r);
    check_val = res_wide;
    if (op_r == OP_MUL)
      check_val = core_acc;
    else if (op_r == OP_DIV)
      check_val = WIDE'(core_quo);
    if (err_pend != ERR_NONE)
      check_err = err_pend;
    else if (check_val > WIDE'(MAXVAL))
      check_err = ERR_RANGE;
    else
      check_err = ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      err_pend <= ERR_NONE;
      res_wide <= '0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      rem      <= '0;
      neg      <= 1'b0;
      err      <= ERR_NONE;
    end else if (clr) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r     <= op;
            a_r      <= a;
            b_r      <= b;
            busy     <= 1'b1;
            cnt      <= '0;
            neg_r    <= 1'b0;
            res_wide <= '0;
            if (range_bad) begin
              err_pend <= ERR_RANGE;
              state    <= ST_CHECK;
            end else if (op == OP_DIV && b == '0) begin
              err_pend <= ERR_DIV0;
              state    <= ST_CHECK;
            end else begin
              err_pend <= ERR_NONE;
              case (op)
                OP_MUL:  state <= ST_MUL;
                OP_DIV:  state <= ST_DIV;
                default: state <= ST_ADDSUB;
              endcase
            end
          end
        end
        ST_ADDSUB: begin
          if (op_r == OP_ADD) begin
            res_wide <= WIDE'(add_sum);
            neg_r    <= 1'b0;
          end else begin
            res_wide <= WIDE'(sub_diff);
            neg_r    <= (a_r < b_r);
          end
          state <= ST_CHECK;
        end
        ST_MUL, ST_DIV: begin
          if (cnt == CW'(W - 1))
            state <= ST_CHECK;
          else
            cnt <= cnt + 1'b1;
        end
        ST_CHECK: begin
          // Visible outputs are only ever updated on the way into DONE.
          done <= 1'b1;
          err  <= check_err;
          if (check_err != ERR_NONE) begin
            result <= '0;
            rem    <= '0;
            neg    <= 1'b0;
          end else begin
            result <= check_val[W-1:0];
            rem    <= (op_r == OP_DIV) ? core_rem : '0;
            neg    <= (op_r == OP_SUB) ? neg_r : 1'b0;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
